// File: rtl/rom_server_pkg.sv
// Shared types and constants for the byte-ROM responder.
// Holds FSM state encodings, the out-of-range fill byte and the default SRAM size.
package rom_server_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_ACK,
      S_RELEASE
   } state_t;

   localparam logic [7:0]  ROMSRV_OOR_BYTE = 8'hFF;
   localparam logic [21:0] ROMSRV_MEMWORDS = 22'h100000;

   function automatic logic [7:0] sel_byte(
      input logic [15:0] w,
      input logic        odd
   );
      return odd ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/rom_server_buf.sv
// One-word read buffer: tag/valid/word registers with hit compare.
// Ports: flush (invalidate), access (FSM in ACCESS), fill + fill_tag/fill_word
// (capture fetched word), look_tag (lookup), hit/word (lookup result).
module rom_server_buf (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        access,
   input  logic        fill,
   input  logic [20:0] fill_tag,
   input  logic [15:0] fill_word,
   input  logic [20:0] look_tag,
   output logic        hit,
   output logic [15:0] word
);

   logic        valid_q, valid_d;
   logic        fl_q, fl_d;
   logic [20:0] tag_q, tag_d;
   logic [15:0] word_q, word_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         fl_q    <= 1'b0;
         tag_q   <= '0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         fl_q    <= fl_d;
         tag_q   <= tag_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      fl_d    = fl_q;
      tag_d   = tag_q;
      word_d  = word_q;
      // fl_q remembers a flush seen earlier in the current fetch
      if (access && flush) fl_d = 1'b1;
      if (fill) begin
         fl_d   = 1'b0;
         tag_d  = fill_tag;
         word_d = fill_word;
         if (!flush && !fl_q) valid_d = 1'b1;
      end
      if (flush) valid_d = 1'b0;
   end

   // a flush arriving with the request forces a miss
   assign hit  = valid_q && !flush && (tag_q == look_tag);
   assign word = word_q;

endmodule

// File: rtl/rom_server.sv
// Byte-ROM responder serving 8-bit reads from 16-bit async SRAM with wait states.
// Ports: romaddr/romreq in, romdata/romack out, flush, memaddr/memdq/memce_n/memoe_n.
// Optional one-word read buffer enabled by ROMSRV_LINEBUF_EN.
module rom_server
   import rom_server_pkg::*;
#(
   parameter int unsigned WAIT     = 2,
   parameter logic [21:0] MEMWORDS = ROMSRV_MEMWORDS
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [21:0] romaddr,
   input  logic        romreq,
   output logic [7:0]  romdata,
   output logic        romack,
   input  logic        flush,
   output logic [20:0] memaddr,
   input  logic [15:0] memdq,
   output logic        memce_n,
   output logic        memoe_n
);

   state_t      state_q, state_d;
   logic        odd_q, odd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  romdata_q, romdata_d;
   logic        romack_q, romack_d;
   logic [20:0] memaddr_q, memaddr_d;
   logic        stb_n_q, stb_n_d;

   logic        oor;
   logic        fill;
   logic        in_access;
   logic        buf_hit;
   logic [15:0] buf_word;

   assign oor       = {1'b0, romaddr} >= {MEMWORDS, 1'b0};
   assign in_access = (state_q == S_ACCESS);
   assign fill      = in_access && (cnt_q == 4'd0);

`ifdef ROMSRV_LINEBUF_EN
   rom_server_buf u_buf (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .access    (in_access),
      .fill      (fill),
      .fill_tag  (memaddr_q),
      .fill_word (memdq),
      .look_tag  (romaddr[21:1]),
      .hit       (buf_hit),
      .word      (buf_word)
   );
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign buf_hit      = 1'b0;
   assign buf_word     = 16'h0000;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         odd_q     <= 1'b0;
         cnt_q     <= '0;
         romdata_q <= '0;
         romack_q  <= 1'b0;
         memaddr_q <= '0;
         stb_n_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         odd_q     <= odd_d;
         cnt_q     <= cnt_d;
         romdata_q <= romdata_d;
         romack_q  <= romack_d;
         memaddr_q <= memaddr_d;
         stb_n_q   <= stb_n_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      odd_d     = odd_q;
      cnt_d     = cnt_q;
      romdata_d = romdata_q;
      romack_d  = 1'b0;
      memaddr_d = memaddr_q;
      stb_n_d   = stb_n_q;
      unique case (state_q)
         S_IDLE: begin
            if (romreq) begin
               odd_d = romaddr[0];
               if (oor) begin
                  state_d   = S_ACK;
                  romack_d  = 1'b1;
                  romdata_d = ROMSRV_OOR_BYTE;
               end else if (buf_hit) begin
                  state_d   = S_ACK;
                  romack_d  = 1'b1;
                  romdata_d = sel_byte(buf_word, romaddr[0]);
               end else begin
                  state_d   = S_ACCESS;
                  memaddr_d = romaddr[21:1];
                  stb_n_d   = 1'b0;
                  cnt_d     = 4'(WAIT);
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_ACK;
               romack_d  = 1'b1;
               romdata_d = sel_byte(memdq, odd_q);
               stb_n_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: state_d = S_RELEASE;
         S_RELEASE: begin
            if (!romreq) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign romdata = romdata_q;
   assign romack  = romack_q;
   assign memaddr = memaddr_q;
   assign memce_n = stb_n_q;
   assign memoe_n = stb_n_q;

endmodule

// File: tb/tb_rom_server.sv
// Directed scoreboard bench for rom_server (default and MEMWORDS=16 instances).
// Expected bytes queued at request time, popped and compared at romack.
module tb_rom_server;

`ifdef ROMSRV_LINEBUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif
   localparam int HL = BUF ? 1 : 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [21:0] romaddr = '0;
   logic        romreq = 1'b0;
   logic        flush = 1'b0;
   logic        sel2 = 1'b0;

   logic        req1, req2;
   logic [7:0]  romdata1, romdata2;
   logic        romack1, romack2;
   logic [20:0] memaddr1, memaddr2;
   logic [15:0] memdq1, memdq2;
   logic        memce_n1, memce_n2, memoe_n1, memoe_n2;

   logic [15:0] sram1 [0:63];
   logic [15:0] sram2 [0:63];

   int nvec = 0;
   int nerr = 0;
   logic [7:0] sbq[$];

   always #5 clk = ~clk;

   assign req1 = romreq & ~sel2;
   assign req2 = romreq & sel2;
   assign memdq1 = (memaddr1 < 21'd64) ? sram1[memaddr1[5:0]] : 16'hDEAD;
   assign memdq2 = (memaddr2 < 21'd64) ? sram2[memaddr2[5:0]] : 16'hDEAD;

   rom_server dut1 (
      .clk(clk), .rstn(rstn), .romaddr(romaddr), .romreq(req1),
      .romdata(romdata1), .romack(romack1), .flush(flush),
      .memaddr(memaddr1), .memdq(memdq1),
      .memce_n(memce_n1), .memoe_n(memoe_n1)
   );

   rom_server #(.MEMWORDS(22'd16)) dut2 (
      .clk(clk), .rstn(rstn), .romaddr(romaddr), .romreq(req2),
      .romdata(romdata2), .romack(romack2), .flush(flush),
      .memaddr(memaddr2), .memdq(memdq2),
      .memce_n(memce_n2), .memoe_n(memoe_n2)
   );

   logic        cur_ack, cur_ce;
   logic [7:0]  cur_data;
   logic [20:0] cur_addr;
   assign cur_ack  = sel2 ? romack2 : romack1;
   assign cur_ce   = sel2 ? memce_n2 : memce_n1;
   assign cur_data = sel2 ? romdata2 : romdata1;
   assign cur_addr = sel2 ? memaddr2 : memaddr1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input bit use2, input logic [21:0] a,
                         input logic [7:0] exp_d, input int exp_lat,
                         input bit exp_stb, input int hold, input bit fl);
      int n;
      int pulses;
      bit got;
      bit stb;
      logic [20:0] ma;
      logic [7:0] d;
      sbq.push_back(exp_d);
      @(negedge clk);
      sel2 = use2;
      romaddr = a;
      romreq = 1'b1;
      n = 0; got = 0; stb = 0; ma = '0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (fl) flush = (n == 1);
         if (cur_ce == 1'b0) begin
            stb = 1'b1;
            ma = cur_addr;
         end
         if (cur_ack) got = 1'b1;
      end
      flush = 1'b0;
      chk("ack_seen", 32'(got), 32'd1);
      romaddr = 22'h3FFFFE;
      d = sbq.pop_front();
      if (got) begin
         chk("romdata", 32'(cur_data), 32'(d));
         chk("latency", 32'(n), 32'(exp_lat));
      end
      chk("strobe", 32'(stb), 32'(exp_stb));
      if (stb) chk("memaddr", 32'(ma), 32'(a[21:1]));
      pulses = 0;
      repeat (hold) begin
         @(negedge clk);
         if (cur_ack) pulses++;
      end
      romreq = 1'b0;
      @(negedge clk);
      if (cur_ack) pulses++;
      chk("extra_ack", 32'(pulses), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         sram1[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
         sram2[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
      end
      sram1[16] = 16'hBEEF;
      sram1[24] = 16'h1234;
      sram2[15] = 16'hC0DE;

      #12;
      chk("rst_ack", 32'(romack1), 32'd0);
      chk("rst_data", 32'(romdata1), 32'd0);
      chk("rst_ce", 32'(memce_n1), 32'd1);
      chk("rst_oe", 32'(memoe_n1), 32'd1);
      chk("rst_addr", 32'(memaddr1), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      do_req(0, 22'h000021, 8'hBE, 4, 1, 1, 0);
      do_req(0, 22'h000020, 8'hEF, HL, !BUF, 1, 0);
      do_req(0, 22'h000021, 8'hBE, HL, !BUF, 5, 0);
      do_req(0, 22'h000021, 8'hBE, HL, !BUF, 1, 0);

      do_req(0, 22'h000031, 8'h12, 4, 1, 1, 0);
      do_req(0, 22'h000021, 8'hBE, 4, 1, 1, 1);
      do_req(0, 22'h000020, 8'hEF, 4, 1, 1, 0);
      do_req(0, 22'h000030, 8'h34, 4, 1, 1, 0);
      do_req(0, 22'h000031, 8'h12, HL, !BUF, 1, 0);
      do_req(0, 22'h000021, 8'hBE, 4, 1, 1, 0);

      do_req(1, 22'h000020, 8'hFF, 1, 0, 1, 0);
      do_req(1, 22'h3FFFFF, 8'hFF, 1, 0, 1, 0);
      do_req(1, 22'h00001F, 8'hC0, 4, 1, 1, 0);

      @(negedge clk);
      sel2 = 1'b0;
      romaddr = 22'h000031;
      romreq = 1'b1;
      @(negedge clk);
      chk("acc_ce", 32'(memce_n1), 32'd0);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_ce", 32'(memce_n1), 32'd1);
      chk("mid_rst_oe", 32'(memoe_n1), 32'd1);
      chk("mid_rst_ack", 32'(romack1), 32'd0);
      chk("mid_rst_data", 32'(romdata1), 32'd0);
      romreq = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      do_req(0, 22'h000020, 8'hEF, 4, 1, 1, 0);
      do_req(0, 22'h000021, 8'hBE, HL, !BUF, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
